inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the main decode/control block in the single-cycle RV32I core.
- Holds the PC and drives a synchronous-read instruction ROM so the fetched word is aligned with the current PC.
- Resolves next-PC from the control block's Branch/BranchType/Jump outputs plus register-file operands and immediate.
- Supplies the instruction word, PC, link address (PC+4) and a retired-instruction counter.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded by reset; must be word-aligned
IMEM_AW  14  ROM word-address width; ROM depth is 2^IMEM_AW words

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  hold current PC/instruction this cycle
Branch  input  1  conditional-branch instruction in decode
BranchType  input  3  funct3 of the branch (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu)
Jump  input  1  jal or jalr in decode
rs1_data  input  32  register-file read port 1
rs2_data  input  32  register-file read port 2
imm  input  32  sign-extended immediate of the current instruction
imem_rdata  input  32  ROM read data; 1-cycle latency from imem_addr
imem_addr  output  IMEM_AW  ROM word address, driven combinationally from the PC about to be loaded
inst  output  32  current instruction (= imem_rdata)
pc  output  32  address of inst
pc_plus4  output  32  pc+4, link value for jal/jalr
inst_valid  output  1  inst/pc pair is valid
trap  output  1  sticky misaligned-target flag
retired  output  32  count of instructions completed since reset

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, inst_valid<=0, trap<=0, retired<=0. While rst=1, imem_addr=RESET_PC[IMEM_AW+1:2], so the ROM word for RESET_PC is present in the first cycle after reset. Reset mid-operation discards any pending branch or stall.
- inst_valid<=1 at the first edge with rst=0, then stays 1 until the next reset.
- jalr detection is internal: inst[6:0]==7'b1100111. jal = Jump and not jalr.
- Branch condition: beq rs1==rs2; bne !=; blt/bge signed; bltu/bgeu unsigned. BranchType 010/011 means not taken.
- Target computation:
  - branch/jal: pc+imm.
  - jalr: (rs1_data+imm) & ~32'h1.
  - All adds are 32-bit and wrap modulo 2^32.
- next_pc priority:
  - rst → RESET_PC.
  - trap or !inst_valid or stall → pc (hold).
  - Jump → jump target.
  - Branch and taken → branch target.
  - Otherwise → pc+4.
- Jump wins if Jump and Branch are both asserted.
- Misalignment: if the selected target has bit1=1 (after the jalr bit0 clear), trap<=1 and pc holds. trap is sticky until rst; while set, pc holds, retired holds, and control inputs are ignored.
- imem_addr = next_pc[IMEM_AW+1:2]; upper PC bits are truncated, so ROM addressing wraps. pc itself is a full 32-bit register.
- pc<=next_pc every edge. inst is valid combinationally throughout the cycle after the edge.
- retired increments by 1 (wrapping at 2^32) on each edge where inst_valid=1, stall=0, trap=0 and no trap is being raised that cycle.
- Stall: pc and ROM address repeat, so inst is unchanged on the next cycle. Branch/Jump are not evaluated while stalled.

Test Plan:
- Reset then free-run with stall=0, Branch=Jump=0 → pc sequence 0,4,8,12; inst = ROM words 0..3; retired=3 on the 4th valid cycle; inst_valid=0 only in the cycle after reset release.
- At pc=0x10: Branch=1, BranchType=000, rs1=rs2=5, imm=-8 → next pc=0x08. With rs2=6 instead → next pc=0x14.
- At pc=0x20: Branch=1, BranchType=100, rs1=0xFFFFFFFF, rs2=1 → taken (signed). BranchType=110 with the same operands → not taken, pc=0x24.
- jalr (inst[6:0]=1100111), Jump=1, rs1=0x101, imm=3 → next pc=0x104, pc_plus4=old pc+4. With rs1=0x102, imm=0 → trap=1 next cycle, pc frozen, retired frozen until rst.
- stall held 3 cycles at pc=0x40 → pc=0x40, inst unchanged, retired unchanged; on release pc=0x44.
- rst asserted while stall=1 and Branch taken → next pc=RESET_PC, retired=0, trap=0, inst_valid=0.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32I fetch stage: PC register, next-PC resolution, ROM address, retire counter
// imem_addr is driven from next-PC so the synchronous ROM returns the word for pc in the following cycle.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               Branch,
  input  logic [2:0]         BranchType,
  input  logic               Jump,
  input  logic [31:0]        rs1_data,
  input  logic [31:0]        rs2_data,
  input  logic [31:0]        imm,
  input  logic [31:0]        imem_rdata,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        inst,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               inst_valid,
  output logic               trap,
  output logic [31:0]        retired
);

  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        trap_q, trap_d;
  logic [31:0] retired_q, retired_d;

  logic        is_jalr;
  logic        taken;
  logic        hold;
  logic        redirect;
  logic        misalign;
  logic [31:0] jalr_sum;
  logic [31:0] pc_imm;
  logic [31:0] target;

  assign inst     = imem_rdata;
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign is_jalr  = (imem_rdata[6:0] == 7'b1100111);
  assign jalr_sum = rs1_data + imm;
  assign pc_imm   = pc_q + imm;

  always_comb begin
    taken = 1'b0;
    case (BranchType)
      3'b000:  taken = (rs1_data == rs2_data);
      3'b001:  taken = (rs1_data != rs2_data);
      3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  taken = (rs1_data <  rs2_data);
      3'b111:  taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

  // Jump outranks Branch; a misaligned redirect freezes pc and raises the sticky trap instead.
  always_comb begin
    hold     = trap_q || !inst_valid_q || stall;
    redirect = !hold && (Jump || (Branch && taken));
    target   = (Jump && is_jalr) ? {jalr_sum[31:1], 1'b0} : pc_imm;
    misalign = redirect && target[1];

    pc_d         = pc_plus4;
    inst_valid_d = 1'b1;
    trap_d       = trap_q | misalign;
    retired_d    = retired_q;

    if (rst) begin
      pc_d         = RESET_PC;
      inst_valid_d = 1'b0;
      trap_d       = 1'b0;
      retired_d    = 32'd0;
    end else if (hold || misalign) begin
      pc_d = pc_q;
    end else begin
      if (redirect) begin
        pc_d = target;
      end
      retired_d = retired_q + 32'd1;
    end
  end

  assign imem_addr = pc_d[IMEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      trap_q       <= 1'b0;
      retired_q    <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      trap_q       <= trap_d;
      retired_q    <= retired_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign trap       = trap_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with a behavioural ROM and reference model
module tb_inst_fetch;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          Branch = 1'b0;
  logic [2:0]    BranchType = 3'd0;
  logic          Jump = 1'b0;
  logic [31:0]   rs1_data = 32'd0;
  logic [31:0]   rs2_data = 32'd0;
  logic [31:0]   imm = 32'd0;
  logic [31:0]   imem_rdata = 32'd0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   inst, pc, pc_plus4, retired;
  logic          inst_valid, trap;

  inst_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .Branch(Branch), .BranchType(BranchType),
    .Jump(Jump), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .inst(inst), .pc(pc),
    .pc_plus4(pc_plus4), .inst_valid(inst_valid), .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [0:(1<<AW)-1];
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        trap;
    logic [31:0] retired;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc = 32'd0;
  logic        m_valid = 1'b0;
  logic        m_trap = 1'b0;
  logic [31:0] m_ret = 32'd0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic s, input logic br, input logic [2:0] bt,
                      input logic j, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im);
    logic [31:0] cur_inst, tgt;
    logic        tk, redir;
    exp_t        e, g;
    @(negedge clk);
    rst = r; stall = s; Branch = br; BranchType = bt; Jump = j;
    rs1_data = a; rs2_data = b; imm = im;
    if (r) begin
      m_pc = 32'd0; m_valid = 1'b0; m_trap = 1'b0; m_ret = 32'd0;
    end else if (m_trap || !m_valid || s) begin
      m_valid = 1'b1;
    end else begin
      cur_inst = rom[m_pc[AW+1:2]];
      case (bt)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = ($signed(a) <  $signed(b));
        3'd5: tk = ($signed(a) >= $signed(b));
        3'd6: tk = (a <  b);
        3'd7: tk = (a >= b);
        default: tk = 1'b0;
      endcase
      redir = j || (br && tk);
      if (j && cur_inst[6:0] == 7'b1100111) tgt = (a + im) & ~32'h1;
      else tgt = m_pc + im;
      if (redir && tgt[1]) begin
        m_trap = 1'b1;
      end else begin
        m_pc  = redir ? tgt : m_pc + 32'd4;
        m_ret = m_ret + 32'd1;
      end
    end
    e.pc = m_pc; e.inst = rom[m_pc[AW+1:2]]; e.valid = m_valid;
    e.trap = m_trap; e.retired = m_ret;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check_eq("pc", pc, g.pc);
    check_eq("pc_plus4", pc_plus4, g.pc + 32'd4);
    check_eq("inst", inst, g.inst);
    check_eq("inst_valid", {31'd0, inst_valid}, {31'd0, g.valid});
    check_eq("trap", {31'd0, trap}, {31'd0, g.trap});
    check_eq("retired", retired, g.retired);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = {8'hA5, 8'(i), 9'd0, 7'h13};
    rom[17] = {8'hA5, 8'd17, 9'd0, 7'h67};
    rom[73] = {8'hA5, 8'd73, 9'd0, 7'h67};

    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    repeat (5) idle();
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'd5, 32'd5, -32'sd8);
    repeat (2) idle();
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'd5, 32'd6, -32'sd8);
    repeat (3) idle();
    step(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, -32'sd4);
    idle();
    step(1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, -32'sd4);
    step(1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 32'd1, 32'd2, 32'h1C);
    repeat (3) step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 32'd7, 32'd7, 32'h100);
    idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'h101, 32'd0, 32'd3);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'h0, 32'd0, 32'h20);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'h102, 32'd0, 32'd0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 32'd4, 32'd4, 32'd8);
    step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 32'd3, 32'd3, 32'h40);
    idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'd0, 32'd0, 32'h400);
    step(1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd8);
    step(1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd8);
    step(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 32'd9, 32'd9, 32'd8);
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 32'd1, 32'd2, 32'h10);
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'd3, 32'd3, 32'd6);
    repeat (2) idle();

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
